// File: rtl/router_pkt_tx_if.sv
// Host/router-side signal bundle for the router packet transmitter.
// Valid/ready: a payload byte moves on a rising edge with wr_en & wr_ready; a beat moves when busy==0.
interface router_pkt_tx_if;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       start;
  logic [1:0] start_addr;
  logic       corrupt_par;
  logic       abort;
  logic       busy;
  logic [7:0] data_out;
  logic       pkt_valid;
  logic       tx_active;
  logic       tx_done;
  logic       tx_abort;
  logic       cmd_err;
  logic [2:0] dbg_state;

  modport master (
    output wr_en, wr_data, start, start_addr, corrupt_par, abort, busy,
    input  wr_ready, data_out, pkt_valid, tx_active, tx_done, tx_abort, cmd_err, dbg_state
  );

  modport slave (
    input  wr_en, wr_data, start, start_addr, corrupt_par, abort, busy,
    output wr_ready, data_out, pkt_valid, tx_active, tx_done, tx_abort, cmd_err, dbg_state
  );
endinterface

// File: rtl/router_pkt_tx.sv
// Packet source for the router ingress: buffers up to 63 payload bytes, then sends
// header {len,addr}, payload and an XOR parity byte while honouring router busy.
module router_pkt_tx #(
  parameter int GAP_CYCLES = 2
) (
  input logic             clk,
  input logic             reset,
  router_pkt_tx_if.slave  bus
);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HEADER  = 3'd1,
    PAYLOAD = 3'd2,
    PARITY  = 3'd3,
    GAP     = 3'd4
  } state_t;

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  state_t        state, state_n;
  logic [5:0]    count;
  logic [5:0]    rd_ptr;
  logic [5:0]    len;
  logic [1:0]    addr;
  logic          corrupt_q;
  logic [7:0]    parity;
  logic [GW-1:0] gap_cnt;
  logic [7:0]    pay_mem [0:63];

  logic xfer, abort_take, start_ok, wr_fire;

  assign abort_take = bus.abort & (state != IDLE);
  assign xfer       = ~bus.busy & ((state == HEADER) | (state == PAYLOAD) | (state == PARITY));
  assign start_ok   = bus.start & (count != 6'd0) & (bus.start_addr != 2'd3);
  assign bus.wr_ready = ~reset & (state == IDLE) & (count != 6'd63) & ~bus.start;
  assign wr_fire    = bus.wr_en & bus.wr_ready;
  assign bus.dbg_state = state;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start_ok) state_n = HEADER;
      HEADER:  if (xfer) state_n = PAYLOAD;
      PAYLOAD: if (xfer && rd_ptr == len - 6'd1) state_n = PARITY;
      PARITY:  if (xfer) state_n = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:     if (gap_cnt == GW'(GAP_LAST)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort_take) state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      rd_ptr      <= '0;
      len         <= '0;
      addr        <= '0;
      corrupt_q   <= 1'b0;
      parity      <= '0;
      gap_cnt     <= '0;
      bus.tx_done  <= 1'b0;
      bus.tx_abort <= 1'b0;
      bus.cmd_err  <= 1'b0;
    end else begin
      state        <= state_n;
      bus.tx_done  <= 1'b0;
      bus.tx_abort <= 1'b0;
      bus.cmd_err  <= 1'b0;
      if (abort_take) begin
        count        <= '0;
        bus.tx_abort <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (wr_fire) count <= count + 6'd1;
            if (start_ok) begin
              len       <= count;
              addr      <= bus.start_addr;
              corrupt_q <= bus.corrupt_par;
            end else if (bus.start) begin
              bus.cmd_err <= 1'b1;
            end
          end
          HEADER: if (xfer) begin
            parity <= {len, addr};
            rd_ptr <= '0;
          end
          PAYLOAD: if (xfer) begin
            parity <= parity ^ pay_mem[rd_ptr];
            rd_ptr <= rd_ptr + 6'd1;
          end
          PARITY: if (xfer) begin
            bus.tx_done <= 1'b1;
            count       <= '0;
            gap_cnt     <= '0;
          end
          GAP: gap_cnt <= gap_cnt + GW'(1);
          default: ;
        endcase
      end
    end
  end

  // Payload storage needs no reset; count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (wr_fire) pay_mem[count] <= bus.wr_data;
  end

  // Router-facing outputs depend only on registered state, so busy/start never reach them.
  always_comb begin
    bus.data_out  = 8'h00;
    bus.pkt_valid = 1'b0;
    case (state)
      HEADER: begin
        bus.data_out  = {len, addr};
        bus.pkt_valid = 1'b1;
      end
      PAYLOAD: begin
        bus.data_out  = pay_mem[rd_ptr];
        bus.pkt_valid = 1'b1;
      end
      PARITY:  bus.data_out = corrupt_q ? ~parity : parity;
      default: ;
    endcase
    if (reset) begin
      bus.data_out  = 8'h00;
      bus.pkt_valid = 1'b0;
    end
  end

  assign bus.tx_active = (state != IDLE);
endmodule
